// File: rtl/ct_rd_arbiter.sv
// ct_rd_arbiter: round-robin sharing of the single ct_mem read port between
// the two crack cores. Grants are combinational, at most one read is issued
// per cycle, and a {valid, owner} pipeline matching the memory latency steers
// each returning word to the core that asked for it.
module ct_rd_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rddata,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rddata,
    output logic          busy
);

    // run_reg stays low until the first edge after reset release, so nothing
    // is granted before the arbiter has seen one clean clock.
    logic              run_reg;
    logic              last_reg;
    logic [AW-1:0]     mem_addr_reg;
    logic [AW-1:0]     mem_addr_next;
    logic [RD_LAT-1:0] valid_reg;
    logic [RD_LAT-1:0] owner_reg;

    logic              req0_m;
    logic              req1_m;
    logic              gnt0_next;
    logic              gnt1_next;
    logic              grant_any;
    logic              grant_core;

    assign req0_m = req0 & run_reg;
    assign req1_m = req1 & run_reg;

    // Round-robin pick: a lone request wins, a tie goes to the core not granted last.
    always_comb begin
        gnt0_next = 1'b0;
        gnt1_next = 1'b0;
        if (req0_m && req1_m) begin
            if (last_reg) begin
                gnt0_next = 1'b1;
            end else begin
                gnt1_next = 1'b1;
            end
        end else if (req0_m) begin
            gnt0_next = 1'b1;
        end else if (req1_m) begin
            gnt1_next = 1'b1;
        end
    end

    assign grant_any  = gnt0_next | gnt1_next;
    assign grant_core = gnt1_next;
    assign gnt0       = gnt0_next;
    assign gnt1       = gnt1_next;

    // Address mux: granted core's address, otherwise the last driven value.
    always_comb begin
        mem_addr_next = mem_addr_reg;
        if (gnt1_next) begin
            mem_addr_next = addr1;
        end else if (gnt0_next) begin
            mem_addr_next = addr0;
        end
    end

    assign mem_addr = mem_addr_next;

    // Run flag, priority pointer, held address and first in-flight stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg      <= 1'b0;
            last_reg     <= 1'b1;
            mem_addr_reg <= '0;
            valid_reg[0] <= 1'b0;
            owner_reg[0] <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            if (grant_any) begin
                last_reg <= grant_core;
            end
            mem_addr_reg <= mem_addr_next;
            valid_reg[0] <= grant_any;
            owner_reg[0] <= grant_core;
        end
    end

    // Remaining in-flight stages follow the memory latency one cycle each.
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_flight
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    owner_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    owner_reg[gi] <= owner_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rvalid0 = valid_reg[RD_LAT-1] & ~owner_reg[RD_LAT-1];
    assign rvalid1 = valid_reg[RD_LAT-1] &  owner_reg[RD_LAT-1];
    assign rddata  = mem_rddata;
    assign busy    = |valid_reg;

endmodule
